// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed data memory: byte/half/word
// accesses, sign/zero-extended loads, and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misalign_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      st, nxt;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic        lat_uns;
  logic [15:0] lat_wdata;
  logic        req_mis;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Shift the addressed lane down to bit 0, then extend to a full word.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {lane, 3'b000};
    r  = w;
    case (size)
      2'b00:   r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    logic [31:0] d;
    m = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {lane, 3'b000};
    d = {16'h0, wd} << {lane, 3'b000};
    return (w & ~m) | (d & m);
  endfunction

  assign req_mis = misaligned(req_size, req_addr[1:0]);

  always_comb begin
    nxt = st;
    case (st)
      IDLE: begin
        if (req_valid) begin
          if (req_mis)                nxt = RESP;
          else if (!req_we)           nxt = RD;
          else if (req_size == 2'b10) nxt = WR;
          else                        nxt = RMW_RD;
        end
      end
      RD:      nxt = RESP;
      RMW_RD:  nxt = WR;
      WR:      nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Every memory-facing output is a flop decoded from the next state, so the
  // level-sensitive memory never sees a combinational glitch from req_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      misalign_err <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      resp_rdata   <= '0;
      lat_size     <= '0;
      lat_lane     <= '0;
      lat_uns      <= 1'b0;
      lat_wdata    <= '0;
    end else begin
      st           <= nxt;
      req_ready    <= (nxt == IDLE);
      resp_valid   <= (nxt == RESP);
      misalign_err <= (st == IDLE) && req_valid && req_mis;
      mem_read     <= (nxt == RD) || (nxt == RMW_RD);
      mem_write    <= (nxt == WR);
      case (st)
        IDLE: begin
          if (req_valid) begin
            lat_size  <= req_size;
            lat_lane  <= req_addr[1:0];
            lat_uns   <= req_unsigned;
            lat_wdata <= req_wdata[15:0];
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we && !req_mis && req_size == 2'b10) mem_wdata <= req_wdata;
          end
        end
        RD:      resp_rdata <= load_extend(mem_rdata, lat_size, lat_lane, lat_uns);
        RMW_RD:  mem_wdata  <= store_merge(mem_rdata, lat_wdata, lat_size, lat_lane);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              misalign_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign_err(misalign_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:127];
  logic        pre_we = 1'b0;
  logic [6:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (mem_write)   mem[mem_addr[8:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end
  assign mem_rdata = mem[mem_addr[8:2]];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic preset(input logic [6:0] idx, input logic [31:0] v);
    @(negedge clk);
    pre_idx = idx; pre_val = v; pre_we = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  int          r_lat, r_nrd, r_nwr, r_clash;
  logic        r_done, r_err;
  logic [31:0] r_rdata, r_wdata;
  logic [8:0]  r_waddr;

  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [8:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_clash = 0; r_done = 1'b0; r_err = 1'b0;
    r_rdata = '0; r_wdata = '0; r_waddr = '0;
    for (int c = 1; c <= 10 && !r_done; c++) begin
      @(negedge clk);
      if (mem_read) r_nrd++;
      if (mem_write) begin r_nwr++; r_waddr = mem_addr; r_wdata = mem_wdata; end
      if (mem_read && mem_write) r_clash++;
      if (resp_valid) begin
        r_done = 1'b1; r_lat = c; r_err = misalign_err; r_rdata = resp_rdata;
      end
    end
    check($sformatf("resp_seen@%03h", addr), {31'b0, r_done}, 32'd1);
    check($sformatf("strobe_clash@%03h", addr), r_clash, 32'd0);
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [8:0] addr, input logic [31:0] exp);
    xact(1'b0, size, uns, addr, 32'h0);
    check({tag, "_data"}, r_rdata, exp);
    check({tag, "_lat"}, r_lat, 32'd2);
    check({tag, "_err"}, {31'b0, r_err}, 32'd0);
  endtask

  task automatic bad_req(input string tag, input logic we, input logic [1:0] size,
                         input logic [8:0] addr, input logic [31:0] keep);
    xact(we, size, 1'b0, addr, 32'hCAFEF00D);
    check({tag, "_lat"}, r_lat, 32'd1);
    check({tag, "_err"}, {31'b0, r_err}, 32'd1);
    check({tag, "_nrd"}, r_nrd, 32'd0);
    check({tag, "_nwr"}, r_nwr, 32'd0);
    check({tag, "_rdata_held"}, r_rdata, keep);
  endtask

  logic [8:0]  b2b_addr [3] = '{9'h010, 9'h030, 9'h020};
  logic [31:0] b2b_exp  [3] = '{32'hDEADBEEF, 32'h80F0007F, 32'h11AA3344};

  initial begin
    int idx, got, last, low_cnt;
    logic saw_resp;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", {23'b0, mem_addr}, 32'h0);
    rst_n = 1'b1;

    // word store then load back
    xact(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    check("sw_lat", r_lat, 32'd2);
    check("sw_nwr", r_nwr, 32'd1);
    check("sw_nrd", r_nrd, 32'd0);
    check("sw_addr", {23'b0, r_waddr}, 32'h010);
    check("sw_data", r_wdata, 32'hDEADBEEF);
    load("lw_010", 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);

    // byte store via read-modify-write
    preset(7'd8, 32'h11223344);
    xact(1'b1, 2'b00, 1'b0, 9'h022, 32'h000000AA);
    check("sb_lat", r_lat, 32'd3);
    check("sb_nrd", r_nrd, 32'd1);
    check("sb_nwr", r_nwr, 32'd1);
    check("sb_addr", {23'b0, r_waddr}, 32'h020);
    check("sb_data", r_wdata, 32'h11AA3344);

    // sub-word loads with sign/zero extension
    preset(7'd12, 32'h80F0007F);
    load("lb_030", 2'b00, 1'b0, 9'h030, 32'h0000007F);
    load("lb_033", 2'b00, 1'b0, 9'h033, 32'hFFFFFF80);
    load("lbu_033", 2'b00, 1'b1, 9'h033, 32'h00000080);
    load("lh_032", 2'b01, 1'b0, 9'h032, 32'hFFFF80F0);
    load("lhu_032", 2'b01, 1'b1, 9'h032, 32'h000080F0);

    // misaligned requests
    bad_req("mis_lh_031", 1'b0, 2'b01, 9'h031, 32'h000080F0);
    bad_req("mis_sw_012", 1'b1, 2'b10, 9'h012, 32'h000080F0);
    bad_req("mis_size11", 1'b0, 2'b11, 9'h000, 32'h000080F0);
    check("mis_mem_untouched", mem[4], 32'hDEADBEEF);

    // back-to-back loads with req_valid held high
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    idx = 0; got = 0; last = 0; low_cnt = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        check($sformatf("b2b_data%0d", got), resp_rdata, b2b_exp[got]);
        check($sformatf("b2b_ready_in_resp%0d", got), {31'b0, req_ready}, 32'd0);
        if (got > 0) check($sformatf("b2b_gap%0d", got), c - last, 32'd3);
        last = c;
        got++;
      end
      if (!req_ready && idx > 0) low_cnt++;
      if (req_ready) begin
        if (idx < 3) begin req_addr = b2b_addr[idx]; req_valid = 1'b1; idx++; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_count", got, 32'd3);
    check("b2b_ready_low_cycles", low_cnt, 32'd6);

    // reset asserted during the write cycle of a halfword store
    preset(7'd16, 32'h55667788);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 9'h040;
    req_wdata = 32'h0000BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("sh_rmw_read", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    check("sh_wr_strobe", {31'b0, mem_write}, 32'd1);
    check("sh_wr_data", mem_wdata, 32'h5566BEEF);
    rst_n = 1'b0;
    #1;
    check("rst_drops_write", {31'b0, mem_write}, 32'd0);
    saw_resp = 1'b0;
    repeat (2) begin @(negedge clk); saw_resp = saw_resp | resp_valid; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); saw_resp = saw_resp | resp_valid; end
    check("rst_no_resp", {31'b0, saw_resp}, 32'd0);
    check("rst_ready_after", {31'b0, req_ready}, 32'd1);
    check("rst_rdata_cleared", resp_rdata, 32'h0);
    check("rst_mem_kept", mem[16], 32'h55667788);
    load("lw_after_rst", 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory.
- Accepts byte, halfword and word load/store requests from the core and performs the matching memory accesses.
- Drives the memory's read/write strobes, address and write data, and returns sign- or zero-extended load data.
- The memory supports only whole-word writes, so sub-word stores use a two-step read-modify-write sequence.
- Requests use a valid/ready handshake; one request is in flight at a time.

Parameters:
ADDR_W, 9, byte-address width; must match the data memory address width. Bits [1:0] select the byte lane.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
req_unsigned  in  1  load zero-extend (1) or sign-extend (0)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data
misalign_err  out  1  pulses with resp_valid when the request was rejected
mem_read  out  1  to data memory MemRead
mem_write  out  1  to data memory MemWrite
mem_addr  out  ADDR_W  to data memory addr, bits [1:0] always 00
mem_wdata  out  32  to data memory write_data
mem_rdata  in  32  from data memory read_data (combinational)

Behaviour:
- Reset: async on rst_n low. State=IDLE; all outputs 0 except req_ready=1; internal latches 0.
- Reset mid-operation aborts the request. mem_write drops immediately, no response is issued, and memory contents are whatever was last written.
- Glitch-free strobes: mem_read, mem_write, mem_addr and mem_wdata come only from flops, with no combinational path from req_* inputs. This is required because the memory writes level-sensitively.
- Lane selection (little-endian):
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - halfword at addr[1] occupies bits [16*addr[1]+15 : 16*addr[1]].
- Misalignment: halfword with addr[0]=1, word with addr[1:0]!=00, or size=11.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: latch we/size/unsigned/addr/wdata and set mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Next state:
    - misaligned → RESP with error flag set;
    - load → RD;
    - word store → WR, with mem_wdata=req_wdata;
    - byte/half store → RMW_RD.
- RD:
  - mem_read=1.
  - At the edge, extract the lane from mem_rdata, extend it to 32 bits, and register it into resp_rdata.
  - Next state RESP.
- RMW_RD:
  - mem_read=1.
  - At the edge, mem_wdata = mem_rdata with the selected lane replaced by the low 8/16 bits of the latched wdata.
  - Next state WR.
- WR: mem_write=1 for exactly one cycle. Next state RESP.
- RESP:
  - resp_valid=1 for one cycle; misalign_err=1 if flagged.
  - Next state IDLE.
  - req_ready=0 in this state, so back-to-back requests are spaced one cycle apart.
- Strobe exclusivity: mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- Latency (cycles from the accepting edge to the resp_valid cycle):
  - load = 2;
  - word store = 2;
  - sub-word store = 3;
  - misaligned = 1.
- resp_rdata is updated only by successful loads and holds its value otherwise. Stores and errors do not change it.
- No memory access occurs on a misaligned request.
- req_* inputs are ignored outside IDLE.
- Address wrap: none. The top word address 0x1FC is valid.

Test Plan:
- Reset, then sw addr=0x010 data=0xDEADBEEF → mem_write high exactly 1 cycle with mem_addr=0x010, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after acceptance. Then lw 0x010 → resp_rdata=0xDEADBEEF.
- Memory word 0x020 = 0x11223344; sb addr=0x022 data=0xAA → RMW_RD read then WR of 0x11AA3344; resp_valid 3 cycles after acceptance.
- Memory word 0x030 = 0x80F0007F:
  - lb 0x030 → 0x0000007F;
  - lb 0x033 → 0xFFFFFF80;
  - lbu 0x033 → 0x00000080;
  - lh 0x032 → 0xFFFF80F0;
  - lhu 0x032 → 0x000080F0.
- Misaligned requests lh 0x031, sw 0x012 and size=11 → resp_valid with misalign_err=1 one cycle after acceptance; mem_read/mem_write stay 0; resp_rdata unchanged.
- Hold req_valid high continuously with three loads → req_ready low during RD/RESP; each request accepted only in IDLE; three responses in order.
- Assert rst_n low during the WR cycle of sh 0x040 → mem_write drops asynchronously; no resp_valid; req_ready=1 after release; a subsequent lw is serviced normally.
